rvfi_commit_tracker: RTL and testbench
======================================

// Module: rvfi_commit_tracker
// PURPOSE
//  Consumer end of the rv32i_monitor_word pipeline. Sits after the WB-stage monitor register.
//  - Accepts one retired monitor word per commit pulse and numbers it (rvfi_order).
//  - Sanitises the rd fields and checks PC continuity between retirements.
//  - Detects the self-loop halt and buffers words in a small FIFO.
//  - Hands words to a trace sink (RVFI checker/logger) over a valid/ready handshake.
// PARAMETERS
//  DEPTH    4   trace FIFO entries; power of 2, >=2
//  ORDER_W  64  width of retirement order counter
// PORTS
//  clk           in   1        system clock; all state updates on posedge
//  rst           in   1        synchronous, active-high reset
//  commit        in   1        in holds a retired instruction this cycle
//  in            in   monword  rv32i_monitor_word from WB monitor register
//  trace_ready   in   1        sink accepts head entry this cycle
//  trace_valid   out  1        FIFO head valid
//  trace_word    out  monword  head entry monitor word (sanitised)
//  trace_order   out  ORDER_W  head entry retirement order
//  halt          out  1        core halted (self-loop retired, FIFO drained)
//  pc_mismatch   out  1        sticky: PC continuity violated
//  mismatch_pc   out  32       pc_rdata of first offending commit
//  overflow      out  1        sticky: commit dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; order=0; exp_pc_vld=0; state=RUN.
//  Accept: acc = commit && state!=HALTED && (!full || pop).
//   - pop = trace_valid && trace_ready.
//   - Push and pop in the same cycle when full are both performed; count is unchanged.
//  Drop: commit && state!=HALTED && !acc sets overflow (sticky). Order does not advance.
//  Order: accepted entry is tagged with order, then order <= order+1. Wraps mod 2^ORDER_W.
//  Sanitise (stored copy only):
//   - load_regfile==0 -> rd_addr=0 and rd_wdata=0.
//   - rd_addr==0 -> rd_wdata=0.
//  PC check, on acc:
//   - If exp_pc_vld and in.pc_rdata!=exp_pc: set pc_mismatch.
//   - mismatch_pc latches in.pc_rdata on the first violation only.
//   - Always: exp_pc <= in.pc_wdata, exp_pc_vld <= 1.
//   - A mismatching entry is still stored.
//  Trap: entries with rvfi_trap=1 are stored and counted like any other; no special action.
//  Latency: word accepted at edge N is visible at trace_valid after edge N. No bypass.
//  Handshake:
//   - trace_word and trace_order are stable while trace_valid && !trace_ready.
//   - trace_valid never drops without a pop.
//  FSM (2-bit):
//   - RUN -> DRAIN on acc with in.pc_rdata==in.pc_wdata. That entry is stored.
//   - DRAIN: commits are accepted normally (pipeline tail). DRAIN -> HALTED when FIFO empty
//     after the pop.
//   - HALTED: halt=1. Commits are ignored (no store, no overflow, no order change).
//     Draining continues. Only rst exits.
//  Reset mid-operation: FIFO contents discarded, sticky flags cleared, order=0, state=RUN.
// STRUCTURE
//  Package rv32i_types: add
//   - rvfi_trace_t {rv32i_monitor_word word; logic [63:0] order;}
//   - enum rvfi_trk_state_t {RUN, DRAIN, HALTED}
//  Sub-module rvfi_trace_fifo:
//   - Parameterised DEPTH, element rvfi_trace_t.
//   - Ports: push, pop, wdata, rdata, full, empty.
//   - Registered read head; simultaneous push/pop when full is legal.
//  Top: sanitise/tag logic, order counter, PC check, FSM.
// TESTING
//  1. Reset, 3 commits pc 0x60->0x64->0x68, ready=1 -> trace_order 0,1,2; each 1 cycle
//     after its commit; pc_mismatch=0.
//  2. ready=0, 5 back-to-back commits (DEPTH=4) -> 4 stored, overflow=1, order of next
//     accept=4. Raise ready -> entries 0..3 drained in order, payload unchanged while stalled.
//  3. Commit pc_rdata=0x100 after pc_wdata=0x104 -> pc_mismatch=1, mismatch_pc=0x100.
//     A later bad PC leaves mismatch_pc=0x100.
//  4. Commit rd_addr=0, rd_wdata=0xDEAD -> trace_word.rd_wdata=0.
//     load_regfile=0, rd_addr=5 -> rd_addr=0.
//  5. Commit pc 0x80->0x80 (jal x0,0), ready=1 -> halt=1 once FIFO empties.
//     Further commits ignored, no overflow.
//  6. rst asserted with 3 entries queued and overflow=1 -> next cycle: trace_valid=0,
//     overflow=0, next accept has order=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32I retirement monitor path: the monitor word, the
// tagged trace entry and the commit tracker state encoding.
package rv32i_types;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic        load_regfile;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rvfi_trap;
  } rv32i_monitor_word;

  typedef struct packed {
    rv32i_monitor_word word;
    logic [63:0]       order;
  } rvfi_trace_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rvfi_trk_state_t;

  // A retirement that writes no register, or writes x0, carries no rd payload.
  function automatic rv32i_monitor_word sanitise_word(input rv32i_monitor_word w);
    rv32i_monitor_word s;
    s = w;
    if (!s.load_regfile) begin
      s.rd_addr  = '0;
      s.rd_wdata = '0;
    end
    if (s.rd_addr == 5'd0) s.rd_wdata = '0;
    return s;
  endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Small register-array FIFO of tagged trace entries. Push and pop in the same
// cycle are legal even when full; the head is read straight from storage.
module rvfi_trace_fifo
  import rv32i_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  rvfi_trace_t wdata,
  output rvfi_trace_t rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  rvfi_trace_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // which slots are meaningful, and a reset-free array maps onto plain flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state is updated with <= only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Consumer end of the monitor-word pipeline: numbers and sanitises retirements,
// checks PC continuity, detects the self-loop halt and queues words for a sink.
module rvfi_commit_tracker
  import rv32i_types::*;
#(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit,
  input  rv32i_monitor_word  in,
  input  logic               trace_ready,
  output logic               trace_valid,
  output rv32i_monitor_word  trace_word,
  output logic [ORDER_W-1:0] trace_order,
  output logic               halt,
  output logic               pc_mismatch,
  output logic [31:0]        mismatch_pc,
  output logic               overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rvfi_trk_state_t    state_q, state_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [31:0]        exp_pc_q, exp_pc_d;
  logic               exp_pc_vld_q, exp_pc_vld_d;
  logic               pc_mismatch_q, pc_mismatch_d;
  logic [31:0]        mismatch_pc_q, mismatch_pc_d;
  logic               overflow_q, overflow_d;

  rvfi_trace_t        fifo_wdata, fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               live, pop, acc, drop;

  assign live = commit && (state_q != HALTED);
  assign pop  = !fifo_empty && trace_ready;
  assign acc  = live && (!fifo_full || pop);
  assign drop = live && !acc;

  assign fifo_wdata.word  = sanitise_word(in);
  assign fifo_wdata.order = 64'(order_q);

  rvfi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every _d gets its hold value first, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    order_d       = order_q;
    exp_pc_d      = exp_pc_q;
    exp_pc_vld_d  = exp_pc_vld_q;
    pc_mismatch_d = pc_mismatch_q;
    mismatch_pc_d = mismatch_pc_q;
    overflow_d    = overflow_q;

    if (acc) begin
      order_d      = order_q + 1'b1;
      exp_pc_d     = in.pc_wdata;
      exp_pc_vld_d = 1'b1;
      if (exp_pc_vld_q && (in.pc_rdata != exp_pc_q)) begin
        pc_mismatch_d = 1'b1;
        if (!pc_mismatch_q) mismatch_pc_d = in.pc_rdata;
      end
    end
    if (drop) overflow_d = 1'b1;

    // The self-loop entry sits in the FIFO on entry to DRAIN, so the FIFO can
    // only empty through a pop that is not matched by a push.
    case (state_q)
      RUN:     if (acc && (in.pc_rdata == in.pc_wdata)) state_d = DRAIN;
      DRAIN:   if (pop && !acc && (fifo_count == CNT_W'(1))) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      order_q       <= '0;
      exp_pc_q      <= '0;
      exp_pc_vld_q  <= 1'b0;
      pc_mismatch_q <= 1'b0;
      mismatch_pc_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      order_q       <= order_d;
      exp_pc_q      <= exp_pc_d;
      exp_pc_vld_q  <= exp_pc_vld_d;
      pc_mismatch_q <= pc_mismatch_d;
      mismatch_pc_q <= mismatch_pc_d;
      overflow_q    <= overflow_d;
    end
  end

  // Head payload is forced to zero while empty so unwritten storage never leaks out.
  assign trace_valid = !fifo_empty;
  assign trace_word  = trace_valid ? fifo_rdata.word : '0;
  assign trace_order = trace_valid ? fifo_rdata.order[ORDER_W-1:0] : '0;
  assign halt        = (state_q == HALTED);
  assign pc_mismatch = pc_mismatch_q;
  assign mismatch_pc = mismatch_pc_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed bench for rvfi_commit_tracker: ordering, backpressure/overflow, PC
// continuity, rd sanitising, self-loop halt and mid-run reset.
module tb_rvfi_commit_tracker;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit;
  rv32i_monitor_word in_w;
  logic              trace_ready;
  logic              trace_valid;
  rv32i_monitor_word trace_word;
  logic [63:0]       trace_order;
  logic              halt;
  logic              pc_mismatch;
  logic [31:0]       mismatch_pc;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(.DEPTH(4), .ORDER_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .in          (in_w),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_word  (trace_word),
    .trace_order (trace_order),
    .halt        (halt),
    .pc_mismatch (pc_mismatch),
    .mismatch_pc (mismatch_pc),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc_r, input logic [31:0] pc_w,
                     input logic load = 1'b1, input logic [4:0] rd = 5'd1,
                     input logic [31:0] wd = 32'h1);
    commit            = 1'b1;
    in_w              = '0;
    in_w.inst         = 32'h0000_0013;
    in_w.pc_rdata     = pc_r;
    in_w.pc_wdata     = pc_w;
    in_w.load_regfile = load;
    in_w.rd_addr      = rd;
    in_w.rd_wdata     = wd;
  endtask

  task automatic idle();
    commit = 1'b0;
    in_w   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    trace_ready = 1'b0;
    idle();

    // 1: reset state, then three in-sequence commits drained as they arrive
    do_reset();
    check("rst_valid",    64'(trace_valid), 64'd0);
    check("rst_order",    trace_order,      64'd0);
    check("rst_halt",     64'(halt),        64'd0);
    check("rst_overflow", 64'(overflow),    64'd0);
    check("rst_mism",     64'(pc_mismatch), 64'd0);
    check("rst_mism_pc",  64'(mismatch_pc), 64'd0);
    trace_ready = 1'b1;
    put(32'h60, 32'h64); step();
    check("t1_valid0", 64'(trace_valid),         64'd1);
    check("t1_order0", trace_order,              64'd0);
    check("t1_pc0",    64'(trace_word.pc_rdata), 64'h60);
    put(32'h64, 32'h68); step();
    check("t1_order1", trace_order,              64'd1);
    check("t1_pc1",    64'(trace_word.pc_rdata), 64'h64);
    put(32'h68, 32'h6c); step();
    check("t1_order2", trace_order,              64'd2);
    check("t1_pc2",    64'(trace_word.pc_rdata), 64'h68);
    idle(); step();
    check("t1_empty",  64'(trace_valid), 64'd0);
    check("t1_mism",   64'(pc_mismatch), 64'd0);

    // 2: stalled sink, five commits into a four-entry FIFO
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(32'h200 + 32'(4*i), 32'h204 + 32'(4*i)); step();
    end
    check("t2_no_ovf_yet", 64'(overflow), 64'd0);
    put(32'h210, 32'h214); step();
    check("t2_overflow", 64'(overflow),    64'd1);
    check("t2_valid",    64'(trace_valid), 64'd1);
    idle(); step(); step();
    check("t2_stall_order", trace_order,              64'd0);
    check("t2_stall_pc",    64'(trace_word.pc_rdata), 64'h200);
    trace_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("t2_drain_order%0d", i), trace_order,              64'(i));
      check($sformatf("t2_drain_pc%0d", i),    64'(trace_word.pc_rdata), 64'(32'h200 + 32'(4*i)));
    end
    step();
    check("t2_drained", 64'(trace_valid), 64'd0);
    put(32'h210, 32'h214); step();
    check("t2_next_order", trace_order,      64'd4);
    check("t2_no_mism",    64'(pc_mismatch), 64'd0);
    idle(); step();

    // 3: PC discontinuity is flagged once; the first offending PC is kept
    do_reset();
    trace_ready = 1'b1;
    put(32'h300, 32'h104); step();
    check("t3_first_ok", 64'(pc_mismatch), 64'd0);
    put(32'h100, 32'h108); step();
    check("t3_mism",        64'(pc_mismatch),         64'd1);
    check("t3_mism_pc",     64'(mismatch_pc),         64'h100);
    check("t3_still_store", 64'(trace_word.pc_rdata), 64'h100);
    put(32'h400, 32'h404); step();
    check("t3_mism_sticky", 64'(pc_mismatch), 64'd1);
    check("t3_mism_pc_kept", 64'(mismatch_pc), 64'h100);
    check("t3_order",       trace_order,      64'd2);

    // 4: rd sanitising on the stored copy
    put(32'h404, 32'h408, 1'b1, 5'd0, 32'hDEAD); step();
    check("t4_x0_wdata", 64'(trace_word.rd_wdata), 64'd0);
    put(32'h408, 32'h40c, 1'b0, 5'd5, 32'h1234); step();
    check("t4_noload_addr",  64'(trace_word.rd_addr),  64'd0);
    check("t4_noload_wdata", 64'(trace_word.rd_wdata), 64'd0);
    put(32'h40c, 32'h410, 1'b1, 5'd7, 32'hCAFE); step();
    check("t4_keep_addr",  64'(trace_word.rd_addr),  64'd7);
    check("t4_keep_wdata", 64'(trace_word.rd_wdata), 64'hCAFE);
    idle(); step();

    // 5: self-loop enters DRAIN, tail is accepted, halt once the FIFO empties
    do_reset();
    trace_ready = 1'b1;
    put(32'h7c, 32'h80); step();
    put(32'h80, 32'h80); step();
    check("t5_loop_order", trace_order, 64'd1);
    check("t5_not_halt",   64'(halt),   64'd0);
    put(32'h80, 32'h84); step();
    check("t5_tail_order", trace_order, 64'd2);
    check("t5_drain_halt", 64'(halt),   64'd0);
    idle(); step();
    check("t5_halt",  64'(halt),        64'd1);
    check("t5_empty", 64'(trace_valid), 64'd0);
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(32'h84 + 32'(4*i), 32'h88 + 32'(4*i)); step();
    end
    idle(); step();
    check("t5_ignored_valid", 64'(trace_valid), 64'd0);
    check("t5_ignored_ovf",   64'(overflow),    64'd0);
    check("t5_halt_held",     64'(halt),        64'd1);

    // 6: reset with entries queued and overflow set
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(32'h500 + 32'(4*i), 32'h504 + 32'(4*i)); step();
    end
    idle();
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    check("t6_queued_order", trace_order,    64'd1);
    check("t6_queued_ovf",   64'(overflow),  64'd1);
    rst = 1'b1;
    step();
    check("t6_rst_valid", 64'(trace_valid), 64'd0);
    check("t6_rst_ovf",   64'(overflow),    64'd0);
    rst = 1'b0;
    trace_ready = 1'b1;
    put(32'h900, 32'h904); step();
    check("t6_order0", trace_order,      64'd0);
    check("t6_valid",  64'(trace_valid), 64'd1);
    check("t6_no_mism", 64'(pc_mismatch), 64'd0);
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
